// File: rtl/mips_pkg.sv
// Shared definitions for the 8-bit MIPS pipeline: datapath widths, memory-mapped
// I/O addresses, flag bit positions and the memory-operation decode.
package mips_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int REG_W  = 5;
    localparam int FLAG_W = 4;

    // Memory-mapped board I/O
    localparam logic [7:0] OUT_ADDR = 8'hFF;
    localparam logic [7:0] IN_ADDR  = 8'hFE;

    // Bit positions inside the 4-bit flag vector
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10
    } mem_op_e;

    // en=0 means no access whatever rw says, so (en=0, rw=1) also decodes to MEM_NONE.
    function automatic mem_op_e decode_mem_op(input logic en, input logic rw);
        mem_op_e op;
        case ({en, rw})
            2'b11:   op = MEM_STORE;
            2'b10:   op = MEM_LOAD;
            default: op = MEM_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port synchronous data memory with a registered read port.
// Contents are not reset; the read register always reflects the addressed word.
module data_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              Clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [0:(2**ADDR_W)-1];

    // Write the addressed word on we, and register the addressed word every cycle.
    always_ff @(posedge Clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        rdata <= mem_r[addr];
    end

endmodule

// File: rtl/memory_stage.sv
// MEM stage of the 8-bit MIPS pipeline: data-memory access, memory-mapped I/O
// decode, input-port synchroniser, writeback select and MEM/WB pipeline registers.
module memory_stage #(
    parameter int          DATA_W   = mips_pkg::DATA_W,
    parameter int          ADDR_W   = mips_pkg::ADDR_W,
    parameter int          REG_W    = mips_pkg::REG_W,
    parameter logic [7:0]  OUT_ADDR = mips_pkg::OUT_ADDR,
    parameter logic [7:0]  IN_ADDR  = mips_pkg::IN_ADDR
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] B_bypass,
    input  logic [3:0]        Flag,
    input  logic              Mem_en_ex,
    input  logic              Mem_rw_ex,
    input  logic              Mem_mux_sel_ex,
    input  logic [REG_W-1:0]  Rw_ex,
    input  logic [DATA_W-1:0] Port_in,
    output logic [DATA_W-1:0] Wb_data,
    output logic [REG_W-1:0]  Rw_mem,
    output logic              Wb_en,
    output logic [3:0]        Flag_mem,
    output logic [DATA_W-1:0] Port_out
);

    import mips_pkg::*;

    // Decoded operation and address qualifiers for the current EX->MEM transfer
    mem_op_e             op_s;
    logic                store_s;
    logic                load_s;
    logic [ADDR_W-1:0]   addr_s;
    logic                hit_out_s;
    logic                hit_in_s;

    // MEM/WB pipeline state
    logic [DATA_W-1:0]   ans_r;
    logic                sel_r;
    logic                load_r;
    logic                io_sel_r;
    logic [DATA_W-1:0]   io_data_r;
    logic [REG_W-1:0]    rw_r;
    logic                wb_en_r;
    logic [3:0]          flag_r;
    logic [DATA_W-1:0]   port_out_r;

    // Two-flop synchroniser for the asynchronous board input
    logic [DATA_W-1:0]   sync1_r;
    logic [DATA_W-1:0]   sync2_r;

    logic [DATA_W-1:0]   ram_rdata_s;
    logic [DATA_W-1:0]   rdata_s;
    logic [DATA_W-1:0]   wb_data_s;

    assign op_s      = decode_mem_op(Mem_en_ex, Mem_rw_ex);
    assign addr_s    = ans_ex[ADDR_W-1:0];
    assign hit_out_s = (ans_ex == OUT_ADDR);
    assign hit_in_s  = (ans_ex == IN_ADDR);
    // A store presented while Rst is high must not touch the array.
    assign store_s   = (op_s == MEM_STORE) && !Rst;
    assign load_s    = (op_s == MEM_LOAD);

    data_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_data_ram (
        .Clk   (Clk),
        .we    (store_s),
        .addr  (addr_s),
        .wdata (B_bypass),
        .rdata (ram_rdata_s)
    );

    // Synchronise Port_in; a load from IN_ADDR sees the value two edges old.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1_r <= {DATA_W{1'b0}};
            sync2_r <= {DATA_W{1'b0}};
        end else begin
            sync1_r <= Port_in;
            sync2_r <= sync1_r;
        end
    end

    // Capture the EX results, control and load-source selection for writeback.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ans_r     <= {DATA_W{1'b0}};
            sel_r     <= 1'b0;
            load_r    <= 1'b0;
            io_sel_r  <= 1'b0;
            io_data_r <= {DATA_W{1'b0}};
            rw_r      <= {REG_W{1'b0}};
            wb_en_r   <= 1'b0;
            flag_r    <= 4'b0000;
        end else begin
            ans_r     <= ans_ex;
            sel_r     <= Mem_mux_sel_ex;
            load_r    <= load_s;
            io_sel_r  <= load_s && hit_in_s;
            io_data_r <= sync2_r;
            rw_r      <= Rw_ex;
            // Stores never write back and R0 is hard-wired to zero.
            wb_en_r   <= (op_s != MEM_STORE) && (Rw_ex != {REG_W{1'b0}});
            flag_r    <= Flag;
        end
    end

    // Output latch: updated only by a store to OUT_ADDR, cleared by reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            port_out_r <= {DATA_W{1'b0}};
        end else if (store_s && hit_out_s) begin
            port_out_r <= B_bypass;
        end else begin
            port_out_r <= port_out_r;
        end
    end

    // Load data source: input port, array, or zero when no load was performed.
    always_comb begin
        rdata_s = {DATA_W{1'b0}};
        case ({load_r, io_sel_r})
            2'b11:   rdata_s = io_data_r;
            2'b10:   rdata_s = ram_rdata_s;
            default: rdata_s = {DATA_W{1'b0}};
        endcase
    end

    // Writeback select between loaded data and the ALU result, both already registered.
    always_comb begin
        wb_data_s = {DATA_W{1'b0}};
        if (sel_r) begin
            wb_data_s = rdata_s;
        end else begin
            wb_data_s = ans_r;
        end
    end

    assign Wb_data  = wb_data_s;
    assign Rw_mem   = rw_r;
    assign Wb_en    = wb_en_r;
    assign Flag_mem = flag_r;
    assign Port_out = port_out_r;

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage: reset, pass-through, store/load,
// board I/O with synchroniser delay, R0 guard, unknown control and address boundaries.
module tb_memory_stage;

    logic       Clk;
    logic       Rst;
    logic [7:0] ans_ex;
    logic [7:0] B_bypass;
    logic [3:0] Flag;
    logic       Mem_en_ex;
    logic       Mem_rw_ex;
    logic       Mem_mux_sel_ex;
    logic [4:0] Rw_ex;
    logic [7:0] Port_in;
    logic [7:0] Wb_data;
    logic [4:0] Rw_mem;
    logic       Wb_en;
    logic [3:0] Flag_mem;
    logic [7:0] Port_out;

    int vec_cnt;
    int miscompare_cnt;

    memory_stage dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .ans_ex         (ans_ex),
        .B_bypass       (B_bypass),
        .Flag           (Flag),
        .Mem_en_ex      (Mem_en_ex),
        .Mem_rw_ex      (Mem_rw_ex),
        .Mem_mux_sel_ex (Mem_mux_sel_ex),
        .Rw_ex          (Rw_ex),
        .Port_in        (Port_in),
        .Wb_data        (Wb_data),
        .Rw_mem         (Rw_mem),
        .Wb_en          (Wb_en),
        .Flag_mem       (Flag_mem),
        .Port_out       (Port_out)
    );

    // Free-running 10 ns clock
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscompare_cnt++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one EX->MEM transfer, clock it, and leave time for outputs to settle.
    task automatic step(input logic en, input logic rw, input logic sel,
                        input logic [7:0] ans, input logic [7:0] b,
                        input logic [4:0] rd, input logic [3:0] flg);
        Mem_en_ex      = en;
        Mem_rw_ex      = rw;
        Mem_mux_sel_ex = sel;
        ans_ex         = ans;
        B_bypass       = b;
        Rw_ex          = rd;
        Flag           = flg;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        vec_cnt        = 0;
        miscompare_cnt = 0;
        Rst      = 1'b1;
        Port_in  = 8'h00;

        // Power-on reset
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'd0, 4'b0000);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'd0, 4'b0000);
        check_eq("por_wb_data", {8'h00, Wb_data}, 16'h0000);
        check_eq("por_wb_en", {15'd0, Wb_en}, 16'h0000);
        check_eq("por_port_out", {8'h00, Port_out}, 16'h0000);
        check_eq("por_rw_mem", {11'd0, Rw_mem}, 16'h0000);
        check_eq("por_flag_mem", {12'd0, Flag_mem}, 16'h0000);
        Rst = 1'b0;

        // Seed 8'hFF with a known value (also drives Port_out)
        step(1'b1, 1'b1, 1'b0, 8'hFF, 8'hC3, 5'd3, 4'b0000);
        check_eq("seed_port_out", {8'h00, Port_out}, 16'h00C3);
        check_eq("seed_store_wb_en", {15'd0, Wb_en}, 16'h0000);

        // Reset held 2 cycles while a store to 8'hFF is presented
        Rst = 1'b1;
        step(1'b1, 1'b1, 1'b0, 8'hFF, 8'h5A, 5'd3, 4'b0101);
        check_eq("rst1_port_out", {8'h00, Port_out}, 16'h0000);
        step(1'b1, 1'b1, 1'b0, 8'hFF, 8'h5A, 5'd3, 4'b0101);
        check_eq("rst2_port_out", {8'h00, Port_out}, 16'h0000);
        check_eq("rst2_wb_en", {15'd0, Wb_en}, 16'h0000);
        check_eq("rst2_wb_data", {8'h00, Wb_data}, 16'h0000);
        check_eq("rst2_flag_mem", {12'd0, Flag_mem}, 16'h0000);
        Rst = 1'b0;
        step(1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, 5'd2, 4'b1001);
        check_eq("rst_dropped_store", {8'h00, Wb_data}, 16'h00C3);
        check_eq("rst_load_wb_en", {15'd0, Wb_en}, 16'h0001);
        check_eq("rst_load_flag", {12'd0, Flag_mem}, 16'h0009);
        check_eq("load_keeps_port_out", {8'h00, Port_out}, 16'h0000);

        // Pass-through of the ALU result
        step(1'b0, 1'b0, 1'b0, 8'h3C, 8'h00, 5'd4, 4'b0010);
        check_eq("pass_wb_data", {8'h00, Wb_data}, 16'h003C);
        check_eq("pass_rw_mem", {11'd0, Rw_mem}, 16'h0004);
        check_eq("pass_wb_en", {15'd0, Wb_en}, 16'h0001);
        check_eq("pass_flag_mem", {12'd0, Flag_mem}, 16'h0002);

        // Store then back-to-back load of the same address
        step(1'b1, 1'b1, 1'b0, 8'h10, 8'hA7, 5'd9, 4'b0000);
        check_eq("store_wb_en", {15'd0, Wb_en}, 16'h0000);
        step(1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 5'd7, 4'b0100);
        check_eq("b2b_load_data", {8'h00, Wb_data}, 16'h00A7);
        check_eq("b2b_load_wb_en", {15'd0, Wb_en}, 16'h0001);
        check_eq("b2b_load_rw", {11'd0, Rw_mem}, 16'h0007);

        // Output port store
        step(1'b1, 1'b1, 1'b0, 8'hFF, 8'h81, 5'd1, 4'b0000);
        check_eq("io_port_out", {8'h00, Port_out}, 16'h0081);

        // Input port through the synchroniser
        Port_in = 8'h3E;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'd0, 4'b0000);
        end
        step(1'b1, 1'b0, 1'b1, 8'hFE, 8'h00, 5'd1, 4'b0000);
        check_eq("io_port_in", {8'h00, Wb_data}, 16'h003E);
        Port_in = 8'h77;
        step(1'b1, 1'b0, 1'b1, 8'hFE, 8'h00, 5'd1, 4'b0000);
        check_eq("sync_lag1", {8'h00, Wb_data}, 16'h003E);
        step(1'b1, 1'b0, 1'b1, 8'hFE, 8'h00, 5'd1, 4'b0000);
        check_eq("sync_lag2", {8'h00, Wb_data}, 16'h003E);
        step(1'b1, 1'b0, 1'b1, 8'hFE, 8'h00, 5'd1, 4'b0000);
        check_eq("sync_arrive", {8'h00, Wb_data}, 16'h0077);

        // Store to IN_ADDR writes the array only; loads there still see the port
        step(1'b1, 1'b1, 1'b0, 8'hFE, 8'h99, 5'd1, 4'b0000);
        check_eq("in_store_port_out", {8'h00, Port_out}, 16'h0081);
        step(1'b1, 1'b0, 1'b1, 8'hFE, 8'h00, 5'd1, 4'b0000);
        check_eq("in_load_port", {8'h00, Wb_data}, 16'h0077);

        // R0 guard
        step(1'b0, 1'b0, 1'b0, 8'h55, 8'h00, 5'd0, 4'b0000);
        check_eq("r0_wb_en", {15'd0, Wb_en}, 16'h0000);
        check_eq("r0_wb_data", {8'h00, Wb_data}, 16'h0055);

        // Unknown control (en=0, rw=1) is no access
        step(1'b1, 1'b1, 1'b0, 8'h20, 8'h11, 5'd6, 4'b0000);
        step(1'b0, 1'b1, 1'b1, 8'h20, 8'hEE, 5'd6, 4'b0000);
        check_eq("noacc_wb_data", {8'h00, Wb_data}, 16'h0000);
        check_eq("noacc_wb_en", {15'd0, Wb_en}, 16'h0001);
        step(1'b1, 1'b0, 1'b1, 8'h20, 8'h00, 5'd6, 4'b0000);
        check_eq("noacc_no_write", {8'h00, Wb_data}, 16'h0011);

        // Address boundaries: no aliasing between 00, FD, FE and FF
        step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 5'd2, 4'b0000);
        step(1'b1, 1'b1, 1'b0, 8'hFD, 8'h00, 5'd2, 4'b0000);
        step(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 5'd2, 4'b0000);
        check_eq("bnd_load_00", {8'h00, Wb_data}, 16'h0000);
        step(1'b1, 1'b0, 1'b1, 8'hFD, 8'h00, 5'd2, 4'b0000);
        check_eq("bnd_load_fd", {8'h00, Wb_data}, 16'h0000);
        step(1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, 5'd2, 4'b0000);
        check_eq("bnd_load_ff", {8'h00, Wb_data}, 16'h0081);
        step(1'b1, 1'b0, 1'b1, 8'hFE, 8'h00, 5'd2, 4'b0000);
        check_eq("bnd_load_fe", {8'h00, Wb_data}, 16'h0077);
        check_eq("bnd_port_out", {8'h00, Port_out}, 16'h0081);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
        $finish;
    end

endmodule
